// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART TX arbiter.
// The slave modport is the arbiter's view; master is the requesters plus transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_byte;
    logic                 start_send;
    logic                 done;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;
    logic                 locked;

    modport slave (
        input  req_valid, req_data, req_last, done,
        output req_ready, tx_byte, start_send, grant_id, busy, locked
    );

    modport master (
        output req_valid, req_data, req_last, done,
        input  req_ready, tx_byte, start_send, grant_id, busy, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter; a multi-byte packet holds the
// channel (locked) until its last byte, and each byte waits for the stop-bit handshake.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_arbiter_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StWaitIdle} state_e;

    state_e           state_q, state_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             locked_q, locked_d;

    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;

    // Locked: only the owner may win. Otherwise search upward from last_grant+1.
    always_comb begin
        winner    = grant_q;
        win_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (locked_q) begin
            win_valid = bus_io.req_valid[grant_q];
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand     = (32'(last_grant_q) + k) % NUM_REQ;
                cand_idx = IDX_W'(cand);
                if (!win_valid && bus_io.req_valid[cand_idx]) begin
                    win_valid = 1'b1;
                    winner    = cand_idx;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    tx_byte_d    = bus_io.req_data[{winner, 3'b000} +: 8];
                    grant_d      = winner;
                    last_grant_d = winner;
                    locked_d     = ~bus_io.req_last[winner];
                    state_d      = StSend;
                end
            end
            StSend:     state_d = StWaitDone;
            StWaitDone: if (bus_io.done)  state_d = StWaitIdle;
            StWaitIdle: if (!bus_io.done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            tx_byte_q    <= 8'h00;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
        end
    end

    // Ready is gated by reset so nothing appears accepted while reset is held.
    assign bus_io.req_ready  = (rst_ni && state_q == StIdle && win_valid) ?
                               (NUM_REQ'(1) << winner) : '0;
    assign bus_io.tx_byte    = tx_byte_q;
    assign bus_io.start_send = (state_q == StSend);
    assign bus_io.grant_id   = grant_q;
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.locked     = locked_q;
endmodule
